simple_bus_arbiter: RTL

SIMPLE_BUS_ARBITER -- requirements
Module: simple_bus_arbiter

---
 rtl/simple_bus_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/simple_bus_arbiter.sv
// Round-robin arbiter that serialises requesters onto one shared datapath,
// holding a single outstanding transaction and timing out a silent datapath.
module simple_bus_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*DATA_W-1:0]  req_data,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [DATA_W-1:0]          bus_data_in,
   output logic                       bus_ready,
   input  logic [DATA_W-1:0]          bus_data_out,
   input  logic                       bus_valid,
   output logic                       rsp_valid,
   output logic [DATA_W-1:0]          rsp_data,
   output logic [$clog2(NUM_REQ)-1:0] rsp_id,
   output logic                       err_timeout
);

   localparam int IDW = $clog2(NUM_REQ);
   localparam int CW  = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t              state, state_n;
   logic [IDW-1:0]      rr_ptr, rr_ptr_n;
   logic [IDW-1:0]      cur_id, cur_id_n;
   logic [CW-1:0]       wait_cnt, wait_cnt_n;
   logic [IDW-1:0]      pick_id, next_ptr;
   logic                pick_found;
   logic [NUM_REQ-1:0]  gnt_n;
   logic [DATA_W-1:0]   bus_data_in_n, rsp_data_n;
   logic                bus_ready_n, rsp_valid_n, err_timeout_n;
   logic [IDW-1:0]      rsp_id_n;

   // First set request at or above rr_ptr, wrapping around.
   always_comb begin
      int       idx;
      logic [IDW-1:0] cand;
      pick_id    = '0;
      pick_found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx  = (int'(rr_ptr) + i) % NUM_REQ;
         cand = IDW'(idx);
         if (!pick_found && req[cand]) begin
            pick_found = 1'b1;
            pick_id    = cand;
         end
      end
   end

   assign next_ptr = (cur_id == IDW'(NUM_REQ - 1)) ? '0 : cur_id + IDW'(1);

   always_comb begin
      state_n       = state;
      rr_ptr_n      = rr_ptr;
      cur_id_n      = cur_id;
      wait_cnt_n    = wait_cnt;
      gnt_n         = '0;
      bus_ready_n   = 1'b0;
      bus_data_in_n = bus_data_in;
      rsp_valid_n   = 1'b0;
      rsp_data_n    = rsp_data;
      rsp_id_n      = rsp_id;
      err_timeout_n = 1'b0;
      unique case (state)
         IDLE: begin
            if (pick_found) begin
               state_n          = ISSUE;
               cur_id_n         = pick_id;
               gnt_n[pick_id]   = 1'b1;
               bus_ready_n      = 1'b1;
               bus_data_in_n    = req_data[int'(pick_id)*DATA_W +: DATA_W];
            end
         end
         ISSUE: begin
            state_n    = WAIT;
            wait_cnt_n = '0;
         end
         WAIT: begin
            // A response on the final cycle wins over the timeout.
            if (bus_valid) begin
               state_n     = IDLE;
               rsp_valid_n = 1'b1;
               rsp_data_n  = bus_data_out;
               rsp_id_n    = cur_id;
               rr_ptr_n    = next_ptr;
            end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
               state_n       = IDLE;
               err_timeout_n = 1'b1;
               rr_ptr_n      = next_ptr;
            end else begin
               wait_cnt_n = wait_cnt + CW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         cur_id      <= '0;
         wait_cnt    <= '0;
         gnt         <= '0;
         bus_ready   <= 1'b0;
         bus_data_in <= '0;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         rsp_id      <= '0;
         err_timeout <= 1'b0;
      end else begin
         state       <= state_n;
         rr_ptr      <= rr_ptr_n;
         cur_id      <= cur_id_n;
         wait_cnt    <= wait_cnt_n;
         gnt         <= gnt_n;
         bus_ready   <= bus_ready_n;
         bus_data_in <= bus_data_in_n;
         rsp_valid   <= rsp_valid_n;
         rsp_data    <= rsp_data_n;
         rsp_id      <= rsp_id_n;
         err_timeout <= err_timeout_n;
      end
   end

endmodule
